rrop_sequencer: RTL and testbench
=================================

# rrop_sequencer

Parametrised control sequencer for register-register instructions on the Phase 1 bus datapath. It replaces hand-written per-instruction T-state sequences with one FSM. The FSM fetches through MAR/MDR, decodes the IR, and drives one-hot register strobes and ALU selects. It adds unary ops, two-word MUL/DIV writeback to HI/LO, a multi-cycle ALU handshake with timeout, fault reporting and a retired-instruction counter.

## Interface
- NREGS, 16: general registers; 8 or 16; IR register fields are always 4 bits.
- ALU_TIMEOUT, 64: max T4 cycles waiting on alu_done for MUL/DIV.
- CNT_W, 16: width of retired counter.
- clock  in  1  system clock; all state on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  begin one instruction; sampled in IDLE only.
- mem_ready  in  1  memory data valid on Mdatain during T1.
- alu_done  in  1  ALU result valid in Z path (MUL/DIV only).
- ir  in  32  IR register contents.
- busy  out  1  high from T0 through the final T-state.
- done  out  1  one-cycle pulse after successful writeback.
- fault  out  1  one-cycle pulse on illegal instruction or ALU timeout.
- retired  out  CNT_W  count of done pulses; wraps.
- Rin, Rout  out  NREGS  one-hot register load / bus-drive strobes.
- PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes.
- alu_sel  out  5  ALU operation; equals opcode during T3/T4, 0 otherwise.

## Operation
- IR fields: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
- Legal opcodes: 0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shra, 6 shl, 7 ror, 8 rol, 15 mul, 16 div, 17 neg, 18 not. All others are illegal.
- Moore FSM. Strobes are decoded from the state register only. Every strobe not listed for a state is 0.
- IDLE: if start, go to T0.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin. Hold T1 until mem_ready. PCin is re-asserted each cycle, which is idempotent because Z is not reloaded.
- T2: MDRout, IRin. Go to T3.
- T3 decode:
  - If the opcode is illegal, or any used register field is >= NREGS, go to FAULT.
  - Binary ops and MUL/DIV: Rout[rb], Yin. Go to T4.
  - NEG/NOT: Rout[rb], alu_sel, Zin. Go to T5.
- T4: Rout[rc], alu_sel, Zin.
  - Binary ops: go to T5.
  - MUL/DIV: hold T4 until alu_done, then go to T5.
  - If ALU_TIMEOUT cycles pass in T4 without alu_done, go to FAULT.
- T5:
  - Binary and unary ops: Zlowout, Rin[ra]. Go to DONE.
  - MUL/DIV: Zlowout, LOin. Go to T6.
- T6 (MUL/DIV only): Zhighout, HIin. Go to DONE.
- DONE: done=1, retired increments, go to IDLE. start is also accepted here, so the next state is T0 directly.
- FAULT: fault=1, no register/HI/LO write, go to IDLE. PC has already advanced.
- Register fields used: ra for binary/unary; rb and rc for binary/MUL/DIV; rb only for NEG/NOT. MUL/DIV ignore ra.
- start while busy or in FAULT is ignored.

## Timing
- Reset: state IDLE, every strobe 0, busy/done/fault 0, retired 0, timeout counter 0.
- Reset mid-instruction takes effect immediately, with no partial writeback after release.
- Binary op with mem_ready already high in T1: busy 6 cycles (T0–T5), done in cycle 7.
- Unary op: 5 busy cycles (T4 skipped).
- MUL/DIV: 7 + W busy cycles, where W = cycles spent in T4 beyond the first.
- Each extra T1 wait cycle adds 1 cycle.
- Timeout counter clears on T4 entry and counts each T4 cycle. FAULT is entered on the cycle after the ALU_TIMEOUT-th T4 cycle with alu_done low.
- alu_done high on the very first T4 cycle gives zero wait.
- alu_done is ignored outside T4.
- retired wraps from 2^CNT_W−1 to 0.

## Test plan
- ADD R2,R5,R6, ir=0x012B0000, mem_ready tied high -> exactly one Rin[2] pulse in cycle 6 of busy; Rout[5] in T3, Rout[6] in T4; alu_sel=0 in T3/T4; done in cycle 7; retired=1.
- AND R2,R5,R6, ir=0x112B0000, mem_ready delayed 3 cycles -> T1 held 4 cycles; alu_sel=2 in T4; busy 9 cycles.
- MUL R3,R1, ir=0x78188000, alu_done asserted on the 4th T4 cycle -> LOin then HIin on consecutive cycles; no Rin pulse; busy 10 cycles.
- NEG R4,R7, ir=0x8A380000 -> no Yin; Rout[7] with Zin in T3; Rin[4] in T5; busy 5 cycles.
- Illegal opcode ir=0xF8000000; then NREGS=8 with ir=0x00948000 (rc=9) -> fault pulse after T3; Rin all 0; retired unchanged.
- DIV with alu_done never asserted -> fault after 64 T4 cycles. Then clear_n low in T4 of a second DIV -> immediate IDLE with all outputs 0.

Source files
------------

// File: rtl/rrop_sequencer.sv
// rrop_sequencer: Moore FSM sequencing fetch, decode and execute of register-register instructions
// Ports: clock, clear_n (async active-low); start/mem_ready/alu_done handshakes; ir = IR contents;
//        busy/done/fault status, retired = wrapping done count; Rin/Rout one-hot register strobes;
//        PCout..LOin datapath strobes; alu_sel = opcode during T3/T4.
module rrop_sequencer #(
    parameter int unsigned NREGS       = 16,
    parameter int unsigned ALU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             mem_ready,
    input  logic             alu_done,
    input  logic [31:0]      ir,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] retired,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [4:0]       alu_sel
);
    localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, FAULT} state_t;
    state_t state, nxt;
    logic [TW-1:0] tcnt;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic muldiv, unary, binary, bad_reg, ok, unused;
    assign {op, ra, rb, rc} = ir[31:15];
    assign unused = ^ir[14:0];
    assign muldiv = op == 5'd15 || op == 5'd16;
    assign unary = op == 5'd17 || op == 5'd18;
    assign binary = op <= 5'd8;
    // ra is only a destination for binary/unary ops, rc only a source for binary and MUL/DIV
    assign bad_reg = 32'(rb) >= NREGS || (!muldiv && 32'(ra) >= NREGS) || (!unary && 32'(rc) >= NREGS);
    assign ok = (binary || muldiv || unary) && !bad_reg;
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            tcnt    <= '0;
            retired <= '0;
        end else begin
            state <= nxt;
            tcnt  <= state == T4 ? tcnt + TW'(1) : '0;
            if (state == DONE) retired <= retired + CNT_W'(1);
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? T0 : IDLE;
            T0:      nxt = T1;
            T1:      nxt = mem_ready ? T2 : T1;
            T2:      nxt = T3;
            T3:      nxt = !ok ? FAULT : unary ? T5 : T4;
            // tcnt holds the number of T4 cycles already completed
            T4:      nxt = (!muldiv || alu_done) ? T5 : tcnt == TW'(ALU_TIMEOUT - 1) ? FAULT : T4;
            T5:      nxt = muldiv ? T6 : DONE;
            T6:      nxt = DONE;
            DONE:    nxt = start ? T0 : IDLE;
            default: nxt = IDLE;
        endcase
    end
    assign busy     = state inside {T0, T1, T2, T3, T4, T5, T6};
    assign done     = state == DONE;
    assign fault    = state == FAULT;
    assign PCout    = state == T0;
    assign MARin    = state == T0;
    assign IncPC    = state == T0;
    assign PCin     = state == T1;
    assign Read     = state == T1;
    assign MDRin    = state == T1;
    assign MDRout   = state == T2;
    assign IRin     = state == T2;
    assign Yin      = state == T3 && ok && !unary;
    assign Zin      = state == T0 || state == T4 || (state == T3 && ok && unary);
    assign Zlowout  = state == T1 || state == T5;
    assign LOin     = state == T5 && muldiv;
    assign Zhighout = state == T6;
    assign HIin     = state == T6;
    assign Rout     = (state == T3 && ok) ? NREGS'(1) << rb : state == T4 ? NREGS'(1) << rc : '0;
    assign Rin      = (state == T5 && !muldiv) ? NREGS'(1) << ra : '0;
    assign alu_sel  = (state == T3 || state == T4) ? op : 5'd0;
endmodule

// File: tb/tb_rrop_sequencer.sv
// tb_rrop_sequencer: scoreboard bench for rrop_sequencer with a cycle-count reference model
module tb_rrop_sequencer;
    localparam int TO = 64;
    typedef struct packed {
        logic            flt;
        logic [7:0]      busy;
        logic [13:0][7:0] sc;
        logic [15:0]     rin;
        logic [15:0]     r1;
        logic [15:0]     r2;
        logic [4:0]      sel;
        logic [15:0]     ret;
    } exp_t;
    logic clock = 0, clear_n = 0, start = 0, mem_ready = 0, alu_done = 0;
    logic [31:0] ir = 0, cur_instr = 0;
    logic busy, done, fault;
    logic [15:0] retired, Rin, Rout;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [4:0] alu_sel;
    logic [13:0] s;
    logic start8 = 0;
    logic [31:0] ir8 = 0, ir8_next = 0;
    logic busy8, done8, fault8;
    logic [2:0] retired8;
    logic [7:0] Rin8, Rout8;
    logic [13:0] s8;
    logic [4:0] sel8;
    int cur_w1 = 0, cur_aw = 1;
    int checks = 0, failures = 0;
    logic [15:0] mcnt = 0;
    exp_t q[$];
    int bcnt, rin_at, lo_at, hi_at;
    logic [13:0][7:0] sc_a;
    logic [15:0] rin_a, r1, r2;
    logic [4:0] sel_a;
    string sn [14] = '{"LOin", "HIin", "Zhighout", "Zlowout", "Zin", "Yin", "IRin",
                       "MDRout", "MDRin", "Read", "MARin", "IncPC", "PCin", "PCout"};
    assign s = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin};
    rrop_sequencer dut (
        .clock(clock), .clear_n(clear_n), .start(start), .mem_ready(mem_ready), .alu_done(alu_done),
        .ir(ir), .busy(busy), .done(done), .fault(fault), .retired(retired), .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .alu_sel(alu_sel)
    );
    rrop_sequencer #(.NREGS(8), .ALU_TIMEOUT(TO), .CNT_W(3)) dut8 (
        .clock(clock), .clear_n(clear_n), .start(start8), .mem_ready(1'b1), .alu_done(1'b1),
        .ir(ir8), .busy(busy8), .done(done8), .fault(fault8), .retired(retired8), .Rin(Rin8), .Rout(Rout8),
        .PCout(s8[13]), .PCin(s8[12]), .IncPC(s8[11]), .MARin(s8[10]), .Read(s8[9]), .MDRin(s8[8]),
        .MDRout(s8[7]), .IRin(s8[6]), .Yin(s8[5]), .Zin(s8[4]), .Zlowout(s8[3]), .Zhighout(s8[2]),
        .HIin(s8[1]), .LOin(s8[0]), .alu_sel(sel8)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        if (IRin) ir <= cur_instr;
        if (s8[6]) ir8 <= ir8_next;
    end
    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask
    // expected response from instruction class, extra T1 waits and the T4 cycle carrying alu_done
    function automatic exp_t model(input logic [31:0] x, input int w1, input int aw);
        exp_t e;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit md, un, ok, dn;
        int t1, t4;
        {op, ra, rb, rc} = x[31:15];
        md = op == 15 || op == 16;
        un = op == 17 || op == 18;
        ok = md || un || op <= 8;
        dn = ok && !(md && aw == 0);
        t1 = 1 + w1;
        t4 = (!ok || un) ? 0 : md ? (aw == 0 ? TO : aw) : 1;
        e = '0;
        e.flt = !dn;
        e.busy = 8'(3 + t1 + t4 + int'(dn) + int'(dn && md));
        e.sc[13] = 1; e.sc[12] = 8'(t1); e.sc[11] = 1; e.sc[10] = 1;
        e.sc[9] = 8'(t1); e.sc[8] = 8'(t1); e.sc[7] = 1; e.sc[6] = 1;
        e.sc[5] = 8'(ok && !un);
        e.sc[4] = 8'(1 + t4 + int'(ok && un));
        e.sc[3] = 8'(t1 + int'(dn));
        e.sc[2] = 8'(dn && md); e.sc[1] = 8'(dn && md); e.sc[0] = 8'(dn && md);
        e.rin = (dn && !md) ? 16'(1) << ra : 16'(0);
        e.r1 = ok ? 16'(1) << rb : 16'(0);
        e.r2 = !ok ? 16'(0) : un ? 16'(1) << rb : 16'(1) << rc;
        e.sel = ok ? op : 5'd0;
        return e;
    endfunction
    task automatic clr();
        bcnt = 0; rin_at = 0; lo_at = 0; hi_at = 0;
        sc_a = '0; rin_a = 0; r1 = 0; r2 = 0; sel_a = 0;
    endtask
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clock);
            if (Read) begin
                mem_ready = k >= cur_w1;
                k++;
            end else begin
                k = 0;
                mem_ready = 1'($urandom);
            end
        end
    end
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clock);
            if (Zin && !PCout && (alu_sel == 5'd15 || alu_sel == 5'd16)) begin
                alu_done = cur_aw != 0 && k + 1 == cur_aw;
                k++;
            end else begin
                k = 0;
                alu_done = 1'($urandom);
            end
        end
    end
    initial begin
        exp_t e;
        clr();
        forever begin
            @(negedge clock);
            if (!clear_n) clr();
            else begin
                if (busy) bcnt++;
                for (int i = 0; i < 14; i++) sc_a[i] = sc_a[i] + 8'(s[i]);
                if (|Rin) begin rin_a |= Rin; rin_at = bcnt; end
                if (|Rout) begin
                    if (r1 == 0) r1 = Rout;
                    r2 = Rout;
                    sel_a = alu_sel;
                end
                if (LOin) lo_at = bcnt;
                if (HIin) hi_at = bcnt;
                if (done || fault) begin
                    if (q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_resp done=%0b fault=%0b exp=none", done, fault);
                    end else begin
                        e = q.pop_front();
                        chk("kind", {done, fault}, e.flt ? 2'b01 : 2'b10);
                        chk("busy_cycles", bcnt, e.busy);
                        for (int i = 0; i < 14; i++) chk(sn[i], sc_a[i], e.sc[i]);
                        chk("rin", rin_a, e.rin);
                        chk("rin_cycle", rin_at, e.rin != 0 ? e.busy : 8'd0);
                        chk("rout_first", r1, e.r1);
                        chk("rout_last", r2, e.r2);
                        chk("alu_sel", sel_a, e.sel);
                        chk("retired", retired, e.ret);
                        if (e.sc[0] != 0) chk("lo_hi_adjacent", hi_at, lo_at + 1);
                    end
                    clr();
                end
            end
        end
    end
    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin @(negedge clock); #1; n++; end
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", q.size());
            q.delete();
        end
    endtask
    task automatic launch(input logic [31:0] x, input int w1, input int aw);
        int n;
        cur_instr = x; cur_w1 = w1; cur_aw = aw;
        start = 1; n = 0;
        do begin @(negedge clock); #1; n++; end while (!busy && n < 5);
        start = 0;
    endtask
    task automatic issue(input logic [31:0] x, input int w1, input int aw);
        exp_t e;
        drain();
        e = model(x, w1, aw);
        e.ret = mcnt;
        if (!e.flt) mcnt++;
        q.push_back(e);
        launch(x, w1, aw);
    endtask
    task automatic run8(input logic [31:0] x, input bit flt, input logic [2:0] ret);
        int n;
        logic [7:0] rin_or;
        bit got;
        ir8_next = x; start8 = 1; n = 0; got = 0; rin_or = 0;
        while (n < 40 && !got) begin
            @(negedge clock); #1; n++;
            if (busy8) start8 = 0;
            rin_or |= Rin8;
            if (done8 || fault8) got = 1;
        end
        start8 = 0;
        chk("dut8_kind", {done8, fault8}, flt ? 2'b01 : 2'b10);
        if (flt) chk("dut8_rin_on_fault", rin_or, 0);
        @(posedge clock); #1;
        chk("dut8_retired", retired8, ret);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int n, r, aw;
        logic [4:0] op;
        logic [2:0] ret8;
        repeat (3) @(negedge clock);
        chk("reset_outs", {busy, done, fault, retired, Rin, Rout, s, alu_sel}, 0);
        chk("reset_outs8", {busy8, done8, fault8, retired8, Rin8, Rout8, s8, sel8}, 0);
        #1 clear_n = 1;
        issue(32'h012B0000, 0, 1);
        issue(32'h112B0000, 3, 1);
        issue(32'h78188000, 0, 4);
        issue(32'h8A380000, 0, 1);
        issue(32'hF8000000, 0, 1);
        issue(32'h78188000, 2, 1);
        issue(32'h94A98000, 1, 1);
        issue(32'h80118000, 0, 0);
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            op = r < 5 ? 5'($urandom_range(0, 8)) : r < 7 ? 5'($urandom_range(15, 16)) :
                 r < 9 ? 5'($urandom_range(17, 18)) :
                 ($urandom_range(0, 1) == 1 ? 5'($urandom_range(9, 14)) : 5'($urandom_range(19, 31)));
            aw = $urandom_range(0, 11) == 0 ? 0 : $urandom_range(1, 6);
            issue({op, 27'($urandom)}, $urandom_range(0, 3), aw);
        end
        drain();
        launch(32'h80118000, 0, 0);
        n = 0;
        while (!(Zin && !PCout && alu_sel == 5'd16) && n < 30) begin @(negedge clock); #1; n++; end
        chk("reach_t4", n < 30, 1);
        repeat (3) @(negedge clock);
        #2 clear_n = 0;
        #1 chk("midreset_outs", {busy, done, fault, retired, Rin, Rout, s, alu_sel}, 0);
        @(negedge clock); #1 clear_n = 1;
        mcnt = 0;
        repeat (4) @(negedge clock); #1;
        chk("post_reset_idle", {busy, done, fault, Rin}, 0);
        issue(32'h012B0000, 0, 1);
        drain();
        ret8 = 0;
        run8(32'h00948000, 1, ret8);
        run8(32'h8A400000, 1, ret8);
        ret8++; run8(32'h8A3F8000, 0, ret8);
        ret8++; run8(32'h7F988000, 0, ret8);
        for (int i = 0; i < 6; i++) begin
            ret8++;
            run8(32'h012B0000, 0, ret8);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
